// File: rtl/as1802_resp_pkg.sv
// Shared constants for the as1802 bus responder: I/O window offsets, CPU state codes, STATUS layout.
package as1802_resp_pkg;

  localparam logic [1:0] IO_OUT    = 2'd0;
  localparam logic [1:0] IO_STATUS = 2'd1;
  localparam logic [1:0] IO_IRQCTL = 2'd2;
  localparam logic [1:0] IO_SPARE  = 2'd3;

  typedef enum logic [1:0] {
    SC_FETCH = 2'b00,
    SC_EXEC  = 2'b01,
    SC_DMA   = 2'b10,
    SC_INT   = 2'b11
  } sc_e;

  localparam int STATUS_PENDING = 7;
  localparam int STATUS_IRQ_EN  = 6;

  function automatic logic [7:0] status_byte(input logic pending, input logic irq_en,
                                             input logic [3:0] ef);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_PENDING] = pending;
    s[STATUS_IRQ_EN]  = irq_en;
    s[3:0]            = ef;
    return s;
  endfunction

endpackage

// File: rtl/as1802_resp_ram.sv
// Single-port synchronous scratch RAM, one-clock registered read; output holds between reads.
module as1802_resp_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/as1802_bus_responder.sv
// Target side of the as1802 CPU bus: address demux, scratch RAM, I/O window, EF sync, interrupts.
// Optional RAM window is built only when AS1802_RESP_RAM_EN is defined.
module as1802_bus_responder
  import as1802_resp_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = 16'h0000,
  parameter int          RAM_AW   = 8,
  parameter logic [15:0] IO_BASE  = 16'hFF00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] address,
  input  logic [7:0] cpu_data,
  input  logic       MRD,
  input  logic       MWR,
  input  logic       TPA,
  input  logic       SC0,
  input  logic       SC1,
  input  logic [3:0] ext_flags,
  input  logic       irq_src,
  output logic [7:0] data_to_cpu,
  output logic       data_oe,
  output logic [3:0] EF,
  output logic       intr,
  output logic [7:0] out_port
);

  logic [7:0]  hi_p0;
  logic        mrd_idle_p0, mwr_idle_p0;
  logic [3:0]  ef_p0, ef_p1;
  logic        irq_prev_p0, irq_edge_p1;
  logic        sc_int_p0;
  logic        irq_en, pending;
  logic [7:0]  rd_data_p1;
  logic        rd_ram_p1;
  logic [7:0]  ram_q;
  logic [7:0]  io_rd;
  logic [15:0] addr;
  logic        io_hit, ram_win, ram_hit;
  logic        mrd_start, mwr_start, rd_start, ack, irq_clr_wr;
  sc_e         sc;

  assign addr      = {hi_p0, address};
  // Idle flags clear on reset, so a strobe held low across reset release is not a start.
  assign mrd_start = ~MRD & mrd_idle_p0;
  assign mwr_start = ~MWR & mwr_idle_p0 & ~rst;
  assign rd_start  = mrd_start & MWR;
  assign io_hit    = (addr[15:2] == IO_BASE[15:2]);
  assign ram_win   = (addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
  assign sc        = sc_e'({SC1, SC0});
  assign ack       = (sc == SC_INT) & ~sc_int_p0;
  assign irq_clr_wr = mwr_start & io_hit & (addr[1:0] == IO_IRQCTL) & cpu_data[1];

`ifdef AS1802_RESP_RAM_EN
  assign ram_hit = ram_win & ~io_hit;

  as1802_resp_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .we    (mwr_start & ram_hit),
    .re    (rd_start & ram_hit),
    .addr  (addr[RAM_AW-1:0]),
    .wdata (cpu_data),
    .rdata (ram_q)
  );
`else
  // Window is still decoded but never claimed: it behaves exactly like unmapped space.
  assign ram_hit = ram_win & 1'b0;
  assign ram_q   = 8'hFF;
`endif

  always_comb begin
    io_rd = 8'h00;
    case (addr[1:0])
      IO_OUT:    io_rd = out_port;
      IO_STATUS: io_rd = status_byte(pending, irq_en, ef_p1);
      IO_IRQCTL: io_rd = {7'b0, irq_en};
      default:   io_rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_p0       <= 8'h00;
      mrd_idle_p0 <= 1'b0;
      mwr_idle_p0 <= 1'b0;
      ef_p0       <= 4'h0;
      ef_p1       <= 4'h0;
      irq_prev_p0 <= 1'b0;
      irq_edge_p1 <= 1'b0;
      sc_int_p0   <= 1'b0;
      irq_en      <= 1'b0;
      pending     <= 1'b0;
      rd_data_p1  <= 8'h00;
      rd_ram_p1   <= 1'b0;
      data_oe     <= 1'b0;
      out_port    <= 8'h00;
    end else begin
      // p0: bus sampling, synchronizers, edge detection
      if (TPA) hi_p0 <= address;
      mrd_idle_p0 <= MRD;
      mwr_idle_p0 <= MWR;
      ef_p0       <= ext_flags;
      ef_p1       <= ef_p0;
      irq_prev_p0 <= irq_src;
      irq_edge_p1 <= irq_src & ~irq_prev_p0;
      sc_int_p0   <= (sc == SC_INT);

      // p1: read data captured at strobe start, held until MRD releases
      if (rd_start) begin
        data_oe    <= io_hit | ram_hit;
        rd_ram_p1  <= ram_hit;
        rd_data_p1 <= io_hit ? io_rd : 8'hFF;
      end else if (MRD) begin
        data_oe <= 1'b0;
      end

      if (mwr_start && io_hit) begin
        case (addr[1:0])
          IO_OUT:    out_port <= cpu_data;
          IO_IRQCTL: irq_en   <= cpu_data[0];
          default:   ;
        endcase
      end

      // A new edge in the same cycle as an ack or clear keeps the request pending.
      if (irq_edge_p1)            pending <= 1'b1;
      else if (ack || irq_clr_wr) pending <= 1'b0;
    end
  end

  assign data_to_cpu = rd_ram_p1 ? ram_q : rd_data_p1;
  assign EF          = ef_p1;
  assign intr        = pending & irq_en;

endmodule

// File: tb/tb_as1802_bus_responder.sv
// Self-checking bench for as1802_bus_responder: directed scenarios plus randomized bus traffic.
module tb_as1802_bus_responder;

  localparam logic [15:0] IO_BASE = 16'hFF00;
`ifdef AS1802_RESP_RAM_EN
  localparam bit RAM_EN = 1'b1;
`else
  localparam bit RAM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] cpu_data = 8'h00;
  logic       MRD = 1'b1, MWR = 1'b1, TPA = 1'b0, SC0 = 1'b0, SC1 = 1'b0;
  logic [3:0] ext_flags = 4'h0;
  logic       irq_src = 1'b0;
  logic [7:0] data_to_cpu;
  logic       data_oe;
  logic [3:0] EF;
  logic       intr;
  logic [7:0] out_port;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model state
  logic [7:0] m_ram [256];
  bit         m_ram_ok [256];
  logic [7:0] m_out = 8'h00;
  logic       m_irq_en = 1'b0;
  logic       m_pending = 1'b0;

  as1802_bus_responder dut (
    .clk(clk), .rst(rst), .address(address), .cpu_data(cpu_data), .MRD(MRD), .MWR(MWR),
    .TPA(TPA), .SC0(SC0), .SC1(SC1), .ext_flags(ext_flags), .irq_src(irq_src),
    .data_to_cpu(data_to_cpu), .data_oe(data_oe), .EF(EF), .intr(intr), .out_port(out_port)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    TPA = 1'b1; address = a[15:8]; tick();
    TPA = 1'b0; address = a[7:0]; cpu_data = d; MWR = 1'b0; tick();
    MWR = 1'b1; tick();
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d2, output logic oe2,
                          output logic oe_after);
    TPA = 1'b1; address = a[15:8]; tick();
    TPA = 1'b0; address = a[7:0]; MRD = 1'b0; tick();
    tick();
    d2 = data_to_cpu; oe2 = data_oe;
    MRD = 1'b1; tick();
    oe_after = data_oe;
  endtask

  function automatic bit in_ram(input logic [15:0] a);
    return RAM_EN && (a[15:8] == 8'h00);
  endfunction

  task automatic test_reset();
    rst = 1'b1; ext_flags = 4'hF; irq_src = 1'b0;
    tick(); tick();
    chk_cnt++; if ({data_to_cpu, data_oe, EF, intr, out_port} !== 22'h0)
      $display("FAIL reset: got d=%h oe=%b ef=%h intr=%b out=%h, want all zero",
               data_to_cpu, data_oe, EF, intr, out_port);
    else pass_cnt++;
    ext_flags = 4'h0;
    rst = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_out_port();
    logic [7:0] d; logic oe, oe_a;
    TPA = 1'b1; address = 8'hFF; tick();
    TPA = 1'b0; address = 8'h00; cpu_data = 8'hA5; MWR = 1'b0; tick();
    chk_cnt++; if (out_port !== 8'hA5) $display("FAIL out_write: got %h want a5", out_port);
    else pass_cnt++;
    MWR = 1'b1; tick();
    m_out = 8'hA5;
    bus_read(IO_BASE, d, oe, oe_a);
    chk_cnt++; if (d !== 8'hA5 || oe !== 1'b1)
      $display("FAIL out_read: got d=%h oe=%b want a5/1", d, oe);
    else pass_cnt++;
    chk_cnt++; if (oe_a !== 1'b0) $display("FAIL oe_release: got %b want 0", oe_a);
    else pass_cnt++;
  endtask

  task automatic test_ram();
    logic [7:0] d; logic oe, oe_a;
    bus_write(16'h0012, 8'h3C);
    if (RAM_EN) begin m_ram[8'h12] = 8'h3C; m_ram_ok[8'h12] = 1'b1; end
    bus_read(16'h0012, d, oe, oe_a);
    chk_cnt++;
    if (RAM_EN ? (d !== 8'h3C || oe !== 1'b1) : (d !== 8'hFF || oe !== 1'b0))
      $display("FAIL ram_rw: got d=%h oe=%b want %h/%b", d, oe,
               RAM_EN ? 8'h3C : 8'hFF, RAM_EN);
    else pass_cnt++;
    bus_read(16'h4000, d, oe, oe_a);
    chk_cnt++; if (d !== 8'hFF || oe !== 1'b0)
      $display("FAIL unmapped_read: got d=%h oe=%b want ff/0", d, oe);
    else pass_cnt++;
  endtask

  task automatic test_ef();
    logic [7:0] d; logic oe, oe_a;
    ext_flags = 4'b1010;
    tick();
    chk_cnt++; if (EF !== 4'h0) $display("FAIL ef_lat1: got %b want 0000", EF);
    else pass_cnt++;
    tick();
    chk_cnt++; if (EF !== 4'b1010) $display("FAIL ef_lat2: got %b want 1010", EF);
    else pass_cnt++;
    bus_read(IO_BASE + 16'd1, d, oe, oe_a);
    chk_cnt++; if (d !== 8'h0A || oe !== 1'b1)
      $display("FAIL status: got d=%h oe=%b want 0a/1", d, oe);
    else pass_cnt++;
  endtask

  task automatic test_irq();
    logic [7:0] d; logic oe, oe_a;
    bus_write(IO_BASE + 16'd2, 8'h01); m_irq_en = 1'b1;
    irq_src = 1'b1; tick();
    chk_cnt++; if (intr !== 1'b0) $display("FAIL intr_early: got %b want 0", intr);
    else pass_cnt++;
    tick();
    chk_cnt++; if (intr !== 1'b1) $display("FAIL intr_rise: got %b want 1", intr);
    else pass_cnt++;
    bus_read(IO_BASE + 16'd1, d, oe, oe_a);
    chk_cnt++; if (d !== 8'hCA) $display("FAIL status_pending: got %h want ca", d);
    else pass_cnt++;
    SC1 = 1'b1; SC0 = 1'b1; tick(); SC1 = 1'b0; SC0 = 1'b0;
    chk_cnt++; if (intr !== 1'b0) $display("FAIL intr_ack: got %b want 0", intr);
    else pass_cnt++;
    irq_src = 1'b0; tick(); irq_src = 1'b1; tick(); tick();
    chk_cnt++; if (intr !== 1'b1) $display("FAIL intr_again: got %b want 1", intr);
    else pass_cnt++;
    bus_write(IO_BASE + 16'd2, 8'h03);
    chk_cnt++; if (intr !== 1'b0) $display("FAIL intr_clear_wr: got %b want 0", intr);
    else pass_cnt++;
    // edge register and ack land on the same clock edge: request must survive
    irq_src = 1'b0; tick(); irq_src = 1'b1; tick();
    SC1 = 1'b1; SC0 = 1'b1; tick(); SC1 = 1'b0; SC0 = 1'b0;
    chk_cnt++; if (intr !== 1'b1) $display("FAIL set_wins: got %b want 1", intr);
    else pass_cnt++;
    tick(); SC1 = 1'b1; SC0 = 1'b1; tick(); SC1 = 1'b0; SC0 = 1'b0;
    chk_cnt++; if (intr !== 1'b0) $display("FAIL intr_ack2: got %b want 0", intr);
    else pass_cnt++;
    irq_src = 1'b0; tick(); tick();
    m_pending = 1'b0;
  endtask

  task automatic test_collision();
    TPA = 1'b1; address = 8'hFF; tick();
    TPA = 1'b0; address = 8'h00; cpu_data = 8'h5A; MRD = 1'b0; MWR = 1'b0; tick();
    chk_cnt++; if (data_oe !== 1'b0) $display("FAIL collide_oe1: got %b want 0", data_oe);
    else pass_cnt++;
    tick();
    chk_cnt++; if (data_oe !== 1'b0) $display("FAIL collide_oe2: got %b want 0", data_oe);
    else pass_cnt++;
    MRD = 1'b1; MWR = 1'b1; tick();
    m_out = 8'h5A;
    chk_cnt++; if (out_port !== 8'h5A) $display("FAIL collide_write: got %h want 5a", out_port);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] a; logic [7:0] wd, d, exp_d; logic oe, oe_a, exp_oe; bit chk_data;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       a = IO_BASE + 16'($urandom_range(0, 3));
        1:       a = {8'h00, 8'($urandom_range(0, 255))};
        default: a = {8'($urandom_range(1, 254)), 8'($urandom_range(0, 255))};
      endcase
      if ($urandom_range(0, 1) == 1) begin
        wd = 8'($urandom_range(0, 255));
        bus_write(a, wd);
        if (a[15:2] == IO_BASE[15:2]) begin
          if (a[1:0] == 2'd0) m_out = wd;
          if (a[1:0] == 2'd2) begin m_irq_en = wd[0]; if (wd[1]) m_pending = 1'b0; end
        end else if (in_ram(a)) begin
          m_ram[a[7:0]] = wd; m_ram_ok[a[7:0]] = 1'b1;
        end
        chk_cnt++; if (out_port !== m_out || intr !== (m_pending & m_irq_en))
          $display("FAIL rnd_wr a=%h: got out=%h intr=%b want %h/%b", a, out_port, intr,
                   m_out, m_pending & m_irq_en);
        else pass_cnt++;
      end else begin
        bus_read(a, d, oe, oe_a);
        chk_data = 1'b1;
        if (a[15:2] == IO_BASE[15:2]) begin
          exp_oe = 1'b1;
          case (a[1:0])
            2'd0: exp_d = m_out;
            2'd1: exp_d = {m_pending, m_irq_en, 2'b00, ext_flags};
            2'd2: exp_d = {7'b0, m_irq_en};
            default: exp_d = 8'h00;
          endcase
        end else if (in_ram(a)) begin
          exp_oe = 1'b1; exp_d = m_ram[a[7:0]]; chk_data = m_ram_ok[a[7:0]];
        end else begin
          exp_oe = 1'b0; exp_d = 8'hFF;
        end
        chk_cnt++;
        if (oe !== exp_oe || oe_a !== 1'b0 || (chk_data && d !== exp_d))
          $display("FAIL rnd_rd a=%h: got d=%h oe=%b rel=%b want %h/%b/0", a, d, oe, oe_a,
                   exp_d, exp_oe);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_strobe();
    TPA = 1'b1; address = 8'hFF; tick();
    TPA = 1'b0; address = 8'h00; MRD = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0; tick(); tick();
    chk_cnt++; if (data_oe !== 1'b0 || out_port !== 8'h00)
      $display("FAIL rst_held: got oe=%b out=%h want 0/00", data_oe, out_port);
    else pass_cnt++;
    TPA = 1'b1; address = 8'hFF; tick();
    TPA = 1'b0; address = 8'h00; tick(); tick();
    chk_cnt++; if (data_oe !== 1'b0) $display("FAIL rst_no_access: got %b want 0", data_oe);
    else pass_cnt++;
    MRD = 1'b1; tick(); MRD = 1'b0; tick();
    chk_cnt++; if (data_oe !== 1'b1 || data_to_cpu !== 8'h00)
      $display("FAIL rst_rearm: got oe=%b d=%h want 1/00", data_oe, data_to_cpu);
    else pass_cnt++;
    MRD = 1'b1; tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_ram_ok[i] = 1'b0;
    test_reset();
    test_out_port();
    test_ram();
    test_ef();
    test_irq();
    test_collision();
    test_random();
    test_reset_strobe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
